// File: rtl/issue_select_n.sv
// issue_select_n: issue-queue select stage.
// Holds up to ENTRIES waiting instructions. Each one is bound to a functional
// unit (FU) when it is allocated. Source operands wake up from broadcast tags.
// Each cycle, every FU grants its oldest ready entry, unless that FU is still
// busy with a multi-cycle op. Grants leave as registered issue packets.
//
// Ports
//   clk_i, rst_n_i       clock, synchronous active-low reset
//   flush_i              squash all entries, FU busy state and pending grants
//   alloc_*              allocation request; transfer when alloc_vld_i & alloc_rdy_o
//   wk_vld_i, wk_tag_i   per-port wakeup broadcast (slice k = port k)
//   iss_*_o              per-FU registered issue packet (slice k = FU k)
//   free_cnt_o           number of invalid entries (registered state)

// One queue entry: payload, operand readiness and age.
module issue_select_n_entry #(
    parameter int FUS   = 2,
    parameter int FU_W  = 1,
    parameter int AGE_W = 6,
    parameter int TAG_W = 5,
    parameter int DLY_W = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      flush_i,
    input  logic                      wr_i,
    input  logic                      gnt_i,
    input  logic [FU_W-1:0]           wr_fu_i,
    input  logic [TAG_W-1:0]          wr_dst_i,
    input  logic                      wr_dstval_i,
    input  logic [DLY_W-1:0]          wr_dly_i,
    input  logic [TAG_W-1:0]          wr_src1_i,
    input  logic [TAG_W-1:0]          wr_src2_i,
    input  logic                      wr_src1_rdy_i,
    input  logic                      wr_src2_rdy_i,
    input  logic [FUS-1:0]            wk_vld_i,
    input  logic [FUS-1:0][TAG_W-1:0] wk_tag_i,
    output logic                      valid_o,
    output logic                      elig_o,
    output logic [FU_W-1:0]           fu_o,
    output logic [TAG_W-1:0]          dst_o,
    output logic                      dstval_o,
    output logic [DLY_W-1:0]          dly_o,
    output logic [AGE_W-1:0]          age_o
);
    logic              valid_q, valid_d;
    logic [FU_W-1:0]   fu_q, fu_d;
    logic [TAG_W-1:0]  dst_q, dst_d;
    logic              dstval_q, dstval_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [TAG_W-1:0]  src1_q, src1_d, src2_q, src2_d;
    logic              r1_q, r1_d, r2_q, r2_d;
    logic [AGE_W-1:0]  age_q, age_d;

    function automatic logic woken(input logic [TAG_W-1:0] tag,
                                   input logic [FUS-1:0] vld,
                                   input logic [FUS-1:0][TAG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < FUS; k++)
            if (vld[k] && (tags[k] == tag)) hit = 1'b1;
        return hit;
    endfunction

    always_comb begin
        valid_d  = valid_q;
        fu_d     = fu_q;
        dst_d    = dst_q;
        dstval_d = dstval_q;
        dly_d    = dly_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        r1_d     = r1_q;
        r2_d     = r2_q;
        age_d    = age_q;
        if (valid_q) begin
            r1_d = r1_q | woken(src1_q, wk_vld_i, wk_tag_i);
            r2_d = r2_q | woken(src2_q, wk_vld_i, wk_tag_i);
            if (age_q != {AGE_W{1'b1}}) age_d = age_q + AGE_W'(1);
        end
        if (gnt_i) valid_d = 1'b0;
        // Writes only target invalid slots, so they never collide with a grant.
        // Wakeups on the allocation cycle are bypassed into the stored ready bits.
        if (wr_i) begin
            valid_d  = 1'b1;
            fu_d     = wr_fu_i;
            dst_d    = wr_dst_i;
            dstval_d = wr_dstval_i;
            dly_d    = wr_dly_i;
            src1_d   = wr_src1_i;
            src2_d   = wr_src2_i;
            r1_d     = wr_src1_rdy_i | woken(wr_src1_i, wk_vld_i, wk_tag_i);
            r2_d     = wr_src2_rdy_i | woken(wr_src2_i, wk_vld_i, wk_tag_i);
            age_d    = '0;
        end
        if (flush_i) valid_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_q  <= 1'b0;
            fu_q     <= '0;
            dst_q    <= '0;
            dstval_q <= 1'b0;
            dly_q    <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            r1_q     <= 1'b0;
            r2_q     <= 1'b0;
            age_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            fu_q     <= fu_d;
            dst_q    <= dst_d;
            dstval_q <= dstval_d;
            dly_q    <= dly_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            age_q    <= age_d;
        end
    end

    assign valid_o  = valid_q;
    assign elig_o   = valid_q & r1_q & r2_q;
    assign fu_o     = fu_q;
    assign dst_o    = dst_q;
    assign dstval_o = dstval_q;
    assign dly_o    = dly_q;
    assign age_o    = age_q;
endmodule

// Per-FU picker: oldest-ready select, busy counter and issue packet register.
module issue_select_n_pick #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3,
    parameter int FU_W    = 1,
    parameter int FU_ID   = 0,
    parameter int AGE_W   = 6,
    parameter int TAG_W   = 5,
    parameter int DLY_W   = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             flush_i,
    input  logic [ENTRIES-1:0]               elig_i,
    input  logic [ENTRIES-1:0][FU_W-1:0]     fu_i,
    input  logic [ENTRIES-1:0][AGE_W-1:0]    age_i,
    input  logic [ENTRIES-1:0][TAG_W-1:0]    dst_i,
    input  logic [ENTRIES-1:0]               dstval_i,
    input  logic [ENTRIES-1:0][DLY_W-1:0]    dly_i,
    output logic                             gnt_o,
    output logic [IDX_W-1:0]                 gnt_idx_o,
    output logic                             iss_vld_o,
    output logic [IDX_W-1:0]                 iss_idx_o,
    output logic [TAG_W-1:0]                 iss_dst_o,
    output logic                             iss_dstval_o,
    output logic [DLY_W-1:0]                 iss_dly_o
);
    logic [DLY_W-1:0] busy_q, busy_d;
    logic             iss_vld_q, iss_vld_d;
    logic [IDX_W-1:0] iss_idx_q, iss_idx_d;
    logic [TAG_W-1:0] iss_dst_q, iss_dst_d;
    logic             iss_dstval_q, iss_dstval_d;
    logic [DLY_W-1:0] iss_dly_q, iss_dly_d;
    logic [AGE_W-1:0] best_age;
    logic             cand;

    // Strictly-greater compare while scanning upward keeps the lowest index on ties.
    always_comb begin
        cand      = 1'b0;
        gnt_idx_o = '0;
        best_age  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (elig_i[i] && (int'(fu_i[i]) == FU_ID) && (!cand || (age_i[i] > best_age))) begin
                cand      = 1'b1;
                gnt_idx_o = IDX_W'(i);
                best_age  = age_i[i];
            end
        end
    end

    assign gnt_o = cand && (busy_q == '0) && !flush_i;

    always_comb begin
        busy_d       = busy_q;
        iss_vld_d    = gnt_o;
        iss_idx_d    = iss_idx_q;
        iss_dst_d    = iss_dst_q;
        iss_dstval_d = iss_dstval_q;
        iss_dly_d    = iss_dly_q;
        if (busy_q != '0) busy_d = busy_q - DLY_W'(1);
        if (gnt_o) begin
            iss_idx_d    = gnt_idx_o;
            iss_dst_d    = dst_i[gnt_idx_o];
            iss_dstval_d = dstval_i[gnt_idx_o];
            iss_dly_d    = dly_i[gnt_idx_o];
            // dly 0/1 is a pipelined FU; otherwise block the next dly-1 cycles.
            busy_d = (dly_i[gnt_idx_o] > DLY_W'(1)) ? dly_i[gnt_idx_o] - DLY_W'(1) : '0;
        end
        if (flush_i) busy_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            busy_q       <= '0;
            iss_vld_q    <= 1'b0;
            iss_idx_q    <= '0;
            iss_dst_q    <= '0;
            iss_dstval_q <= 1'b0;
            iss_dly_q    <= '0;
        end else begin
            busy_q       <= busy_d;
            iss_vld_q    <= iss_vld_d;
            iss_idx_q    <= iss_idx_d;
            iss_dst_q    <= iss_dst_d;
            iss_dstval_q <= iss_dstval_d;
            iss_dly_q    <= iss_dly_d;
        end
    end

    assign iss_vld_o    = iss_vld_q;
    assign iss_idx_o    = iss_idx_q;
    assign iss_dst_o    = iss_dst_q;
    assign iss_dstval_o = iss_dstval_q;
    assign iss_dly_o    = iss_dly_q;
endmodule

module issue_select_n #(
    parameter int  ENTRIES = 8,
    parameter int  FUS     = 2,
    parameter int  AGE_W   = 6,
    parameter int  TAG_W   = 5,
    parameter int  DLY_W   = 4,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int FU_W    = (FUS > 1) ? $clog2(FUS) : 1,
    localparam int CNT_W   = $clog2(ENTRIES + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      flush_i,
    input  logic                      alloc_vld_i,
    output logic                      alloc_rdy_o,
    input  logic [FU_W-1:0]           alloc_fu_i,
    input  logic [TAG_W-1:0]          alloc_dst_i,
    input  logic                      alloc_dstval_i,
    input  logic [DLY_W-1:0]          alloc_dly_i,
    input  logic [TAG_W-1:0]          alloc_src1_i,
    input  logic [TAG_W-1:0]          alloc_src2_i,
    input  logic                      alloc_src1_rdy_i,
    input  logic                      alloc_src2_rdy_i,
    input  logic [FUS-1:0]            wk_vld_i,
    input  logic [FUS-1:0][TAG_W-1:0] wk_tag_i,
    output logic [FUS-1:0]            iss_vld_o,
    output logic [FUS-1:0][IDX_W-1:0] iss_idx_o,
    output logic [FUS-1:0][TAG_W-1:0] iss_dst_o,
    output logic [FUS-1:0]            iss_dstval_o,
    output logic [FUS-1:0][DLY_W-1:0] iss_dly_o,
    output logic [CNT_W-1:0]          free_cnt_o
);
    logic [ENTRIES-1:0]             ent_vld, ent_elig, ent_wr, ent_gnt, ent_dstval;
    logic [ENTRIES-1:0][FU_W-1:0]   ent_fu;
    logic [ENTRIES-1:0][AGE_W-1:0]  ent_age;
    logic [ENTRIES-1:0][TAG_W-1:0]  ent_dst;
    logic [ENTRIES-1:0][DLY_W-1:0]  ent_dly;
    logic [FUS-1:0]                 pk_gnt;
    logic [FUS-1:0][IDX_W-1:0]      pk_idx;
    logic [CNT_W-1:0]               free_cnt;
    logic [IDX_W-1:0]               alloc_idx;
    logic                           alloc_ok;

    // Free count and lowest free slot both come from registered valid bits, so a
    // slot freed by this cycle's grant only becomes allocatable next cycle.
    always_comb begin
        free_cnt  = '0;
        alloc_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!ent_vld[i]) begin
                free_cnt  = free_cnt + CNT_W'(1);
                alloc_idx = IDX_W'(i);
            end
        end
    end

    assign free_cnt_o  = free_cnt;
    assign alloc_rdy_o = (free_cnt != '0);
    // Out-of-range FU bindings are dropped rather than stranding an entry forever.
    assign alloc_ok    = alloc_vld_i && alloc_rdy_o && (int'(alloc_fu_i) < FUS);

    always_comb begin
        ent_wr  = '0;
        ent_gnt = '0;
        for (int i = 0; i < ENTRIES; i++)
            ent_wr[i] = alloc_ok && (alloc_idx == IDX_W'(i));
        for (int k = 0; k < FUS; k++)
            if (pk_gnt[k]) ent_gnt[pk_idx[k]] = 1'b1;
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
        issue_select_n_entry #(
            .FUS(FUS), .FU_W(FU_W), .AGE_W(AGE_W), .TAG_W(TAG_W), .DLY_W(DLY_W)
        ) u_ent (
            .clk_i         (clk_i),
            .rst_n_i       (rst_n_i),
            .flush_i       (flush_i),
            .wr_i          (ent_wr[i]),
            .gnt_i         (ent_gnt[i]),
            .wr_fu_i       (alloc_fu_i),
            .wr_dst_i      (alloc_dst_i),
            .wr_dstval_i   (alloc_dstval_i),
            .wr_dly_i      (alloc_dly_i),
            .wr_src1_i     (alloc_src1_i),
            .wr_src2_i     (alloc_src2_i),
            .wr_src1_rdy_i (alloc_src1_rdy_i),
            .wr_src2_rdy_i (alloc_src2_rdy_i),
            .wk_vld_i      (wk_vld_i),
            .wk_tag_i      (wk_tag_i),
            .valid_o       (ent_vld[i]),
            .elig_o        (ent_elig[i]),
            .fu_o          (ent_fu[i]),
            .dst_o         (ent_dst[i]),
            .dstval_o      (ent_dstval[i]),
            .dly_o         (ent_dly[i]),
            .age_o         (ent_age[i])
        );
    end

    for (genvar k = 0; k < FUS; k++) begin : g_fu
        issue_select_n_pick #(
            .ENTRIES(ENTRIES), .IDX_W(IDX_W), .FU_W(FU_W), .FU_ID(k),
            .AGE_W(AGE_W), .TAG_W(TAG_W), .DLY_W(DLY_W)
        ) u_pick (
            .clk_i        (clk_i),
            .rst_n_i      (rst_n_i),
            .flush_i      (flush_i),
            .elig_i       (ent_elig),
            .fu_i         (ent_fu),
            .age_i        (ent_age),
            .dst_i        (ent_dst),
            .dstval_i     (ent_dstval),
            .dly_i        (ent_dly),
            .gnt_o        (pk_gnt[k]),
            .gnt_idx_o    (pk_idx[k]),
            .iss_vld_o    (iss_vld_o[k]),
            .iss_idx_o    (iss_idx_o[k]),
            .iss_dst_o    (iss_dst_o[k]),
            .iss_dstval_o (iss_dstval_o[k]),
            .iss_dly_o    (iss_dly_o[k])
        );
    end
endmodule

// File: doc/issue_select_n.md
# issue_select_n

Parametrised issue-queue select stage for the out-of-order back end. It holds up to ENTRIES waiting instructions, each bound at allocation to one of FUS functional units. It wakes source operands from broadcast tags and picks, per FU and per cycle, the oldest ready entry. Multi-cycle (non-pipelined) FUs are blocked via busy counters. Grants leave as registered issue packets carrying destination tag and latency for the downstream tag broadcast.

## Interface
- ENTRIES, 8, queue depth (≥2); IDX_W = clog2(ENTRIES)
- FUS, 2, functional-unit count (≥1); FU_W = max(1, clog2(FUS))
- AGE_W, 6, per-entry age counter width (saturating)
- TAG_W, 5, physical register tag width
- DLY_W, 4, FU occupancy/latency field width
- clk in 1 — single clock, all state on rising edge
- rst_n in 1 — synchronous, active-low reset
- flush in 1 — squash all entries and FU busy state
- alloc_vld in 1; alloc_rdy out 1 — allocation handshake, transfer when both high
- alloc_fu in FU_W; alloc_dst in TAG_W; alloc_dstval in 1; alloc_dly in DLY_W
- alloc_src1 / alloc_src2 in TAG_W each; alloc_src1_rdy / alloc_src2_rdy in 1 each
- wk_vld in FUS; wk_tag in FUS*TAG_W — wakeup broadcast ports
- iss_vld out FUS; iss_idx out FUS*IDX_W; iss_dst out FUS*TAG_W; iss_dstval out FUS; iss_dly out FUS*DLY_W — per-FU issue packet, slice k = FU k
- free_cnt out clog2(ENTRIES+1) — number of invalid entries

## Operation
- Entry state: valid, fu, dst, dstval, dly, src1/src2 tag + rdy, age.
- Allocation: alloc_rdy = (free_cnt != 0), from registered state only. On transfer, write to the lowest-index invalid entry, age = 0. Apply same-cycle wakeup bypass: a src whose tag equals any wk_tag with wk_vld set is stored ready. A transfer with alloc_fu ≥ FUS is dropped with no entry written.
- Wakeup: each cycle, any valid entry src with a tag match on an asserted wk port sets its rdy bit. Wakeup never clears rdy.
- Age: each valid entry increments age every cycle, saturating at 2^AGE_W−1.
- Eligibility in cycle t: valid and src1_rdy and src2_rdy, all from registered state. An entry allocated or woken in cycle t is not eligible until t+1.
- Select per FU k: among eligible entries with fu == k, choose max age. Ties go to the lowest index. No grant if busy[k] != 0.
- Grant to entry e for FU k: at the edge, iss_vld[k]=1, iss_idx=e, iss_dst/dstval/dly copied from e, valid[e]=0. busy[k] = (dly>1) ? dly−1 : 0.
- Busy: each nonzero busy[k] decrements by 1 per cycle. dly 0 or 1 means a fully pipelined FU.
- An entry is bound to one FU, so no entry is ever granted on two FUs.
- Flush: at the edge all valid=0, busy=0, iss_vld=0. Flush has priority over simultaneous allocation, wakeup and grant, which are all discarded.
- Freeing on grant and allocation in the same cycle: the freed slot is not visible to alloc_rdy until the next cycle.

## Timing
- Reset (rst_n low at an edge): all valid=0, age=0, busy=0. Outputs iss_vld=0, iss_idx=0, iss_dst=0, iss_dstval=0, iss_dly=0, free_cnt=ENTRIES, alloc_rdy=1.
- Latencies:
  - Allocation at edge t → entry eligible in cycle t+1 if both srcs are ready.
  - Selected in cycle t → iss_vld high in cycle t+1 for exactly one cycle.
  - Wakeup at edge t → eligible from cycle t+1.
- Throughput: one issue per FU per cycle when dly ≤ 1; one per dly cycles otherwise.
- free_cnt and alloc_rdy reflect the registered state after the previous edge.

## Test plan
- Reset then idle: free_cnt=8, alloc_rdy=1, iss_vld=00 throughout.
- Allocate 3 ready entries to FU0 in consecutive cycles, dly=1 → iss_vld[0] on three consecutive cycles with iss_idx 0,1,2 (oldest first). iss_dst matches each allocation.
- Fill all 8 entries with unready srcs → alloc_rdy=0, extra alloc ignored. Wake tag 5 on wk port 1 → only entries with both srcs now ready issue, one cycle after wake, routed to their bound FU.
- FU1 entries with dly=3, both ready at once → issues spaced 3 cycles apart. FU0 traffic is unaffected in the same window.
- Allocation cycle with alloc_src1=7, alloc_src1_rdy=0 and wk_tag=7 valid → entry issues two cycles after allocation.
- Flush asserted while 5 entries are valid and busy[1]=2 → next cycle free_cnt=8, iss_vld=00. A following allocation issues on FU1 with no busy stall.
